frame_pipeline_sequencer: RTL and testbench

//  Cycle-accurate controller for the per-frame noise-estimation -> Wiener pipeline.

---
 rtl/frame_pipeline_sequencer.sv | 160 ++++++++++++++++
 tb/tb_frame_pipeline_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/frame_pipeline_sequencer.sv
// frame_pipeline_sequencer: sequences enables/strobes for the noise-estimation -> Wiener
// frame pipeline, with row gaps, wiener bypass, a one-deep pending queue and overrun reporting.
module frame_pipeline_sequencer #(
    parameter int BLOCK_SIZE   = 8,
    parameter int ROW_GAP      = 4,
    parameter int DRAIN_BLOCKS = 2,
    parameter int BLK_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_ready,
    input  logic [BLK_W-1:0] blocks_per_frame,
    input  logic             bypass_wiener,
    input  logic             rlast_ne,
    input  logic             rlast_wn,
    input  logic             estimated_noise_ready,
    output logic             ne_en,
    output logic             ne_start_data,
    output logic             ne_start_of_frame,
    output logic             wn_stats_en,
    output logic             wn_calc_en,
    output logic             wn_start_data,
    output logic             wn_start_of_frame,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_count,
    output logic             err_overrun
);
    localparam int RW   = $clog2(BLOCK_SIZE + 1);
    localparam int CMAX = BLOCK_SIZE > ROW_GAP ? BLOCK_SIZE : ROW_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = BLK_W + 1;

    typedef enum logic [3:0] {
        IDLE, NE_START, NE_ROW, NE_HOLD, NE_GAP, NE_WAIT, WN_START, WN_ROW, WN_GAP, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    blk_q, blk_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BLK_W-1:0] bpf_q, bpf_d;
    logic             byp_q, byp_d, pend_q, pend_d, err_q, err_d;
    logic [8:0]       flags_q, flags_d;
    logic [15:0]      frame_count_q;
    logic             leave, row_last, gap_end, real_blk, wn_row_end;
    logic [BW-1:0]    last_blk;

    assign leave      = state_q == IDLE && pend_q;
    assign row_last   = row_q == RW'(BLOCK_SIZE - 1);
    assign gap_end    = cnt_q == CW'(ROW_GAP - 1);
    assign real_blk   = blk_q < BW'(bpf_q);
    assign last_blk   = BW'(bpf_q) + BW'(DRAIN_BLOCKS - 1);
    // drain blocks have no reader behind them, so their rows are self-timed
    assign wn_row_end = real_blk ? rlast_wn : cnt_q == CW'(BLOCK_SIZE - 1);

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        bpf_d   = bpf_q;
        byp_d   = byp_q;
        case (state_q)
            IDLE: if (pend_q) begin
                bpf_d   = blocks_per_frame;
                byp_d   = bypass_wiener;
                blk_d   = '0;
                row_d   = '0;
                state_d = blocks_per_frame == '0 ? DONE : NE_START;
            end
            NE_START: state_d = NE_ROW;
            NE_ROW: if (rlast_ne) begin
                row_d   = row_last ? '0 : row_q + 1'b1;
                cnt_d   = '0;
                state_d = row_last ? NE_HOLD : NE_GAP;
            end
            NE_HOLD: begin
                blk_d   = blk_q + 1'b1;
                state_d = blk_q + 1'b1 < BW'(bpf_q) ? NE_START : NE_WAIT;
            end
            NE_GAP: begin
                cnt_d   = gap_end ? '0 : cnt_q + 1'b1;
                state_d = gap_end ? NE_ROW : NE_GAP;
            end
            NE_WAIT: if (estimated_noise_ready) begin
                blk_d   = '0;
                state_d = byp_q ? DONE : WN_START;
            end
            WN_START: begin
                cnt_d   = '0;
                state_d = WN_ROW;
            end
            WN_ROW: begin
                cnt_d = cnt_q + 1'b1;
                if (wn_row_end) begin
                    cnt_d   = '0;
                    row_d   = row_last ? '0 : row_q + 1'b1;
                    blk_d   = row_last ? blk_q + 1'b1 : blk_q;
                    state_d = !row_last ? WN_GAP : blk_q == last_blk ? DONE : WN_START;
                end
            end
            WN_GAP: begin
                cnt_d   = gap_end ? '0 : cnt_q + 1'b1;
                state_d = gap_end ? WN_ROW : WN_GAP;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // a frame arriving while pending is held (and not being consumed this cycle) is dropped
    assign pend_d = frame_ready | (pend_q & ~leave);
    assign err_d  = frame_ready & pend_q & ~leave;

    // outputs are decoded from the next state so each registered output lines up with its state
    always_comb begin
        flags_d    = '0;
        flags_d[0] = state_d inside {NE_START, NE_ROW, NE_HOLD};
        flags_d[1] = state_d == NE_START;
        flags_d[2] = state_d == NE_START && blk_d == '0;
        flags_d[3] = state_d inside {WN_START, WN_ROW};
        flags_d[4] = state_d inside {WN_START, WN_ROW} || (state_d == WN_GAP && cnt_d == '0);
        flags_d[5] = state_d == WN_START && blk_d < BW'(bpf_d);
        flags_d[6] = state_d == WN_START && blk_d == '0;
        flags_d[7] = state_d != IDLE;
        flags_d[8] = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            blk_q         <= '0;
            row_q         <= '0;
            cnt_q         <= '0;
            bpf_q         <= '0;
            byp_q         <= 1'b0;
            pend_q        <= 1'b0;
            err_q         <= 1'b0;
            flags_q       <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            blk_q         <= blk_d;
            row_q         <= row_d;
            cnt_q         <= cnt_d;
            bpf_q         <= bpf_d;
            byp_q         <= byp_d;
            pend_q        <= pend_d;
            err_q         <= err_d;
            flags_q       <= flags_d;
            frame_count_q <= frame_count_q + 16'(state_d == DONE);
        end
    end

    assign {frame_done, busy, wn_start_of_frame, wn_start_data, wn_calc_en, wn_stats_en,
            ne_start_of_frame, ne_start_data, ne_en} = flags_q;
    assign frame_count = frame_count_q;
    assign err_overrun = err_q;
endmodule

// File: tb/tb_frame_pipeline_sequencer.sv
// tb_frame_pipeline_sequencer: builds each frame's expected waveform as a concatenation of
// row/gap/wait segments, drives the reader handshakes from it and compares every cycle.
module tb_frame_pipeline_sequencer;
    localparam int BS = 8, RG = 4, DR = 2;
    localparam logic [8:0] EN = 9'h001, SD = 9'h002, SOF = 9'h004, WS = 9'h008, WC = 9'h010,
                           WD = 9'h020, WF = 9'h040, BY = 9'h080, FD = 9'h100;

    logic        clk = 0, rst_n = 0, frame_ready = 0, bypass_wiener = 0;
    logic        rlast_ne = 0, rlast_wn = 0, estimated_noise_ready = 0;
    logic [15:0] blocks_per_frame = 0;
    logic        ne_en, ne_start_data, ne_start_of_frame, wn_stats_en, wn_calc_en;
    logic        wn_start_data, wn_start_of_frame, busy, frame_done, err_overrun;
    logic [15:0] frame_count;
    logic [8:0]  ov;

    frame_pipeline_sequencer #(.BLOCK_SIZE(BS), .ROW_GAP(RG), .DRAIN_BLOCKS(DR), .BLK_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .frame_ready(frame_ready), .blocks_per_frame(blocks_per_frame),
        .bypass_wiener(bypass_wiener), .rlast_ne(rlast_ne), .rlast_wn(rlast_wn),
        .estimated_noise_ready(estimated_noise_ready), .ne_en(ne_en), .ne_start_data(ne_start_data),
        .ne_start_of_frame(ne_start_of_frame), .wn_stats_en(wn_stats_en), .wn_calc_en(wn_calc_en),
        .wn_start_data(wn_start_data), .wn_start_of_frame(wn_start_of_frame), .busy(busy),
        .frame_done(frame_done), .frame_count(frame_count), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;
    assign ov = {frame_done, busy, wn_start_of_frame, wn_start_data, wn_calc_en, wn_stats_en,
                 ne_start_of_frame, ne_start_data, ne_en};

    int checks = 0, errors = 0;
    bit pend = 0, err_exp = 0;
    logic [15:0] fc_m = 0;
    int n_nesd, n_nesof, n_wnsd, n_wnsof, n_fd, n_err, wmid;
    logic [8:0] eq[$];
    bit qa[$], qb[$], qc[$], qf[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h exp %h", tag, $time, got, exp);
        end
    endtask

    function automatic bit jk();
        return $urandom_range(0, 3) == 0;
    endfunction

    task automatic push(input logic [8:0] v, input bit a, input bit b, input bit c);
        eq.push_back(v); qa.push_back(a); qb.push_back(b); qc.push_back(c); qf.push_back(0);
    endtask

    task automatic clr();
        n_nesd = 0; n_nesof = 0; n_wnsd = 0; n_wnsof = 0; n_fd = 0; n_err = 0;
    endtask

    // rows of length fl (0 = random); reader strobes sit on the last cycle of each row
    task automatic build(input int bpf, input bit byp, input int fl, input int w);
        int l;
        eq.delete(); qa.delete(); qb.delete(); qc.delete(); qf.delete();
        wmid = -1;
        for (int b = 0; b < bpf; b++) begin
            push(BY | EN | SD | (b == 0 ? SOF : 9'h0), jk(), jk(), jk());
            for (int r = 0; r < BS; r++) begin
                l = fl > 0 ? fl : int'($urandom_range(1, 6));
                for (int k = 0; k < l; k++) push(BY | EN, k == l - 1, jk(), jk());
                if (r < BS - 1) repeat (RG) push(BY, jk(), jk(), jk());
                else push(BY | EN, jk(), jk(), jk());
            end
        end
        if (bpf > 0) begin
            for (int k = 0; k < w; k++) push(BY, jk(), jk(), k == w - 1);
            if (!byp) for (int b = 0; b < bpf + DR; b++) begin
                push(BY | WS | WC | (b < bpf ? WD : 9'h0) | (b == 0 ? WF : 9'h0), jk(), jk(), jk());
                for (int r = 0; r < BS; r++) begin
                    l = b >= bpf ? BS : fl > 0 ? fl : int'($urandom_range(1, 6));
                    for (int k = 0; k < l; k++) begin
                        if (b == 1 && r == 1 && k == 1) wmid = eq.size();
                        push(BY | WS | WC, jk(), b < bpf ? k == l - 1 : jk(), jk());
                    end
                    if (r < BS - 1) begin
                        push(BY | WC, jk(), jk(), jk());
                        repeat (RG - 1) push(BY, jk(), jk(), jk());
                    end
                end
            end
        end
        push(BY | FD, jk(), jk(), jk());
        push(9'h0, 0, 0, 0);
    endtask

    task automatic cyc(input logic [8:0] v, input bit a, input bit b, input bit c, input bit f);
        rlast_ne = a; rlast_wn = b; estimated_noise_ready = c; frame_ready = f;
        if (v[8]) fc_m++;
        @(negedge clk);
        chk("cycle", {7'd0, err_overrun, frame_count, ov}, {7'd0, err_exp, fc_m, v});
        n_nesd += int'(ne_start_data); n_nesof += int'(ne_start_of_frame);
        n_wnsd += int'(wn_start_data); n_wnsof += int'(wn_start_of_frame);
        n_fd += int'(frame_done); n_err += int'(err_overrun);
        err_exp = f && pend;
        if (f) pend = 1;
        @(posedge clk); #1;
    endtask

    // p1/p2: extra frame_ready positions in the body (-1 none, -2 random); abort -2 = mid WN_ROW
    task automatic run_frame(input int bpf, input bit byp, input int fl, input int w,
                             input int p1, input int p2, input int abort);
        int ab;
        bit stop = 0;
        build(bpf, byp, fl, w);
        ab = abort == -2 ? wmid : abort;
        if (p1 == -2) p1 = $urandom_range(0, eq.size() - 2);
        if (p2 == -2) p2 = $urandom_range(0, eq.size() - 2);
        if (p1 >= 0) qf[p1] = 1;
        if (p2 >= 0) qf[p2] = 1;
        if (!pend) begin
            blocks_per_frame = 16'(bpf); bypass_wiener = byp;
            repeat ($urandom_range(0, 2)) cyc(9'h0, 0, 0, 0, 0);
            cyc(9'h0, 0, 0, 0, 1);
            cyc(9'h0, 0, 0, 0, 0);
        end
        pend = 0;
        for (int i = 0; i < eq.size() && !stop; i++) begin
            if (i == ab) begin
                rlast_ne = qa[i]; rlast_wn = qb[i]; estimated_noise_ready = qc[i]; frame_ready = 0;
                #2 rst_n = 0;
                #1 chk("async_reset", {7'd0, err_overrun, frame_count, ov}, 32'h0);
                pend = 0; fc_m = 0; err_exp = 0; stop = 1;
            end else cyc(eq[i], qa[i], qb[i], qc[i], qf[i]);
        end
    endtask

    initial begin
        int bpf;
        bit byp;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {7'd0, err_overrun, frame_count, ov}, 32'h0);
        rst_n = 1;
        @(posedge clk); #1;

        clr();
        run_frame(4, 0, 8, 20, -1, -1, -1);
        chk("t1_ne_start", n_nesd, 4);
        chk("t1_ne_sof", n_nesof, 1);
        chk("t1_wn_start", n_wnsd, 4);
        chk("t1_wn_sof", n_wnsof, 1);
        chk("t1_done", n_fd, 1);
        chk("t1_count", 32'(frame_count), 1);

        clr();
        run_frame(4, 1, 0, $urandom_range(1, 30), -1, -1, -1);
        chk("t2_wn_start", n_wnsd + n_wnsof, 0);
        chk("t2_done", n_fd, 1);

        clr();
        run_frame(0, 0, 0, 1, -1, -1, -1);
        chk("t3_ne_start", n_nesd, 0);
        chk("t3_done", n_fd, 1);

        clr();
        run_frame(1, 0, 0, 5, 8, 18, -1);
        chk("t4_queued", 32'(pend), 1);
        run_frame(1, 0, 0, 5, -1, -1, -1);
        chk("t4_overrun", n_err, 1);
        chk("t4_done", n_fd, 2);
        chk("t4_count", 32'(frame_count), 5);

        run_frame(2, 0, 4, 10, -1, -1, -2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hold", {7'd0, err_overrun, frame_count, ov}, 32'h0);
        rst_n = 1;
        @(posedge clk); #1;
        clr();
        run_frame(1, 0, 0, 8, -1, -1, -1);
        chk("t5_ne_sof", n_nesof, 1);
        chk("t5_count", 32'(frame_count), 1);

        bpf = 1; byp = 0;
        for (int f = 0; f < 14; f++) begin
            if (!pend) begin
                bpf = $urandom_range(0, 3);
                byp = $urandom_range(0, 3) == 0;
            end
            run_frame(bpf, byp, 0, $urandom_range(1, 30),
                      $urandom_range(0, 2) == 0 ? -2 : -1, $urandom_range(0, 3) == 0 ? -2 : -1, -1);
        end
        if (pend) run_frame(bpf, byp, 0, 5, -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
